// File: rtl/tdm_pkg.sv
// tdm_pkg: shared defaults for the TDM demux and the lane-pointer width helper
package tdm_pkg;
  localparam int N_CH_DEF = 4;
  localparam int W_DEF = 8;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tdm_demux_if.sv
// tdm_demux_if: TDM demux bus; in_valid/in_ready/in_data/in_sof word stream, out_valid/out_ready/out_data lanes, ch_ptr, frame_done/frame_err
interface tdm_demux_if
  import tdm_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int W = W_DEF
) ();
  localparam int CH_W = ch_w(N_CH);
  logic in_valid;
  logic in_ready;
  logic [W-1:0] in_data;
  logic in_sof;
  logic [N_CH-1:0] out_valid;
  logic [N_CH-1:0] out_ready;
  logic [N_CH*W-1:0] out_data;
  logic [CH_W-1:0] ch_ptr;
  logic frame_done;
  logic frame_err;
  modport master (
    output in_valid, in_data, in_sof, out_ready,
    input in_ready, out_valid, out_data, ch_ptr, frame_done, frame_err
  );
  modport slave (
    input in_valid, in_data, in_sof, out_ready,
    output in_ready, out_valid, out_data, ch_ptr, frame_done, frame_err
  );
endinterface

// File: rtl/tdm_lane.sv
// tdm_lane: one-entry valid/ready word buffer; load/d fill it, ready drains it, valid/q present it
module tdm_lane #(
  parameter int W = 8
) (
  input logic clk,
  input logic rst,
  input logic load,
  input logic [W-1:0] d,
  input logic ready,
  output logic valid,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q <= '0;
    end else begin
      valid <= load || (valid && !ready);
      if (load) q <= d;
    end
  end
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: round-robin TDM receive demux; clk/rst plus bus (word stream in, N_CH buffered lanes out, ch_ptr, frame pulses)
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int W = W_DEF
) (
  input logic clk,
  input logic rst,
  tdm_demux_if.slave bus
);
  localparam int CH_W = ch_w(N_CH);
  logic [CH_W-1:0] target;
  logic last;
  logic accept;
  logic [N_CH-1:0] load;
  always_comb begin
    target = bus.in_sof ? '0 : bus.ch_ptr;
    last = target == CH_W'(N_CH - 1);
    bus.in_ready = !bus.out_valid[target] || bus.out_ready[target];
    accept = bus.in_valid && bus.in_ready;
    load = accept ? N_CH'(1) << target : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ch_ptr <= '0;
      bus.frame_done <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.frame_done <= accept && last;
      bus.frame_err <= accept && bus.in_sof && bus.ch_ptr != '0;
      if (accept) bus.ch_ptr <= last ? '0 : target + 1'b1;
    end
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    tdm_lane #(.W(W)) u_lane (
      .clk(clk),
      .rst(rst),
      .load(load[i]),
      .d(bus.in_data),
      .ready(bus.out_ready[i]),
      .valid(bus.out_valid[i]),
      .q(bus.out_data[i*W +: W])
    );
  end
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: scoreboard bench for tdm_demux at N_CH=4/W=8 and N_CH=3/W=16
module tb_tdm_demux;
  typedef struct {
    int lane;
    logic [15:0] d;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [3:0] mva;
  logic [1:0] mpa;
  logic edone_a, eerr_a;
  logic [2:0] mvb;
  logic [1:0] mpb;
  logic edone_b, eerr_b;
  int done_a = 0;
  int done_b = 0;
  logic bad_ptr_b = 1'b0;
  logic [3:0] sa_stall;
  logic [7:0] sa_hold[4];
  bit rdone = 1'b0;
  tdm_demux_if #(.N_CH(4), .W(8)) ia ();
  tdm_demux_if #(.N_CH(3), .W(16)) ib ();
  tdm_demux #(.N_CH(4), .W(8)) ua (.clk(clk), .rst(rst), .bus(ia.slave));
  tdm_demux #(.N_CH(3), .W(16)) ub (.clk(clk), .rst(rst), .bus(ib.slave));
  always #5 clk = ~clk;
  wire [1:0] tgta = ia.in_sof ? 2'd0 : mpa;
  wire mrdya = !mva[tgta] || ia.out_ready[tgta];
  wire acca = ia.in_valid && mrdya;
  wire [1:0] tgtb = ib.in_sof ? 2'd0 : mpb;
  wire mrdyb = !mvb[tgtb] || ib.out_ready[tgtb];
  wire accb = ib.in_valid && mrdyb;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      mva <= '0; mpa <= '0; edone_a <= 1'b0; eerr_a <= 1'b0; qa.delete();
      mvb <= '0; mpb <= '0; edone_b <= 1'b0; eerr_b <= 1'b0; qb.delete();
    end else begin
      mva <= (mva & ~ia.out_ready) | (acca ? 4'b0001 << tgta : 4'b0000);
      edone_a <= acca && tgta == 2'd3;
      eerr_a <= acca && ia.in_sof && mpa != 2'd0;
      if (acca) begin
        mpa <= (tgta == 2'd3) ? 2'd0 : tgta + 2'd1;
        qa.push_back('{int'(tgta), {8'h00, ia.in_data}});
      end
      mvb <= (mvb & ~ib.out_ready) | (accb ? 3'b001 << tgtb : 3'b000);
      edone_b <= accb && tgtb == 2'd2;
      eerr_b <= accb && ib.in_sof && mpb != 2'd0;
      if (accb) begin
        mpb <= (tgtb == 2'd2) ? 2'd0 : tgtb + 2'd1;
        qb.push_back('{int'(tgtb), ib.in_data});
      end
    end
  end
  task automatic pop_a(input int ln);
    int idx;
    idx = -1;
    for (int k = 0; k < qa.size(); k++) if (idx < 0 && qa[k].lane == ln) idx = k;
    if (idx < 0) begin
      checks++; errors++;
      $display("FAIL a_drain lane %0d: got word %h, expected no word", ln, ia.out_data[ln*8 +: 8]);
    end else begin
      chk($sformatf("a_lane%0d_data", ln), 32'(ia.out_data[ln*8 +: 8]), 32'(qa[idx].d));
      qa.delete(idx);
    end
  endtask
  task automatic pop_b(input int ln);
    int idx;
    idx = -1;
    for (int k = 0; k < qb.size(); k++) if (idx < 0 && qb[k].lane == ln) idx = k;
    if (idx < 0) begin
      checks++; errors++;
      $display("FAIL b_drain lane %0d: got word %h, expected no word", ln, ib.out_data[ln*16 +: 16]);
    end else begin
      chk($sformatf("b_lane%0d_data", ln), 32'(ib.out_data[ln*16 +: 16]), 32'(qb[idx].d));
      qb.delete(idx);
    end
  endtask
  always @(negedge clk) begin
    if (rst) sa_stall = '0;
    else begin
      chk("a_in_ready", 32'(ia.in_ready), 32'(mrdya));
      chk("a_out_valid", 32'(ia.out_valid), 32'(mva));
      chk("a_ch_ptr", 32'(ia.ch_ptr), 32'(mpa));
      chk("a_frame_done", 32'(ia.frame_done), 32'(edone_a));
      chk("a_frame_err", 32'(ia.frame_err), 32'(eerr_a));
      if (ia.frame_done) done_a++;
      for (int i = 0; i < 4; i++) begin
        if (sa_stall[i]) chk($sformatf("a_hold%0d", i), 32'(ia.out_data[i*8 +: 8]), 32'(sa_hold[i]));
        if (ia.out_valid[i] && ia.out_ready[i]) pop_a(i);
        sa_stall[i] = ia.out_valid[i] && !ia.out_ready[i];
        sa_hold[i] = ia.out_data[i*8 +: 8];
      end
      chk("b_in_ready", 32'(ib.in_ready), 32'(mrdyb));
      chk("b_out_valid", 32'(ib.out_valid), 32'(mvb));
      chk("b_ch_ptr", 32'(ib.ch_ptr), 32'(mpb));
      chk("b_frame_done", 32'(ib.frame_done), 32'(edone_b));
      chk("b_frame_err", 32'(ib.frame_err), 32'(eerr_b));
      if (ib.frame_done) done_b++;
      if (ib.ch_ptr > 2'd2) bad_ptr_b = 1'b1;
      for (int i = 0; i < 3; i++) if (ib.out_valid[i] && ib.out_ready[i]) pop_b(i);
    end
  end
  task automatic send_a(input logic sof, input logic [7:0] d);
    int n;
    n = 0;
    ia.in_valid = 1'b1; ia.in_sof = sof; ia.in_data = d;
    @(negedge clk);
    while (!mrdya && n < 1000) begin n++; @(negedge clk); end
    chk("a_accept", 32'(mrdya), 32'd1);
    @(posedge clk); #1;
    ia.in_valid = 1'b0; ia.in_sof = 1'b0;
  endtask
  task automatic send_b(input logic sof, input logic [15:0] d);
    int n;
    n = 0;
    ib.in_valid = 1'b1; ib.in_sof = sof; ib.in_data = d;
    @(negedge clk);
    while (!mrdyb && n < 1000) begin n++; @(negedge clk); end
    chk("b_accept", 32'(mrdyb), 32'd1);
    @(posedge clk); #1;
    ib.in_valid = 1'b0; ib.in_sof = 1'b0;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int c0;
    ia.in_valid = 1'b0; ia.in_sof = 1'b0; ia.in_data = '0; ia.out_ready = 4'hF;
    ib.in_valid = 1'b0; ib.in_sof = 1'b0; ib.in_data = '0; ib.out_ready = 3'h7;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(ia.out_valid), 32'd0);
    chk("rst_out_data", ia.out_data, 32'd0);
    chk("rst_ch_ptr", 32'(ia.ch_ptr), 32'd0);
    chk("rst_pulses", {30'd0, ia.frame_done, ia.frame_err}, 32'd0);
    rst = 1'b0;
    c0 = done_a;
    for (int i = 0; i < 4; i++) begin
      send_a(i == 0, 8'h10 + 8'(i));
      chk($sformatf("t1_lane%0d", i), 32'(ia.out_data[i*8 +: 8]), 32'h10 + 32'(i));
      chk($sformatf("t1_valid%0d", i), 32'(ia.out_valid[i]), 32'd1);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("t1_done_count", 32'(done_a - c0), 32'd1);
    chk("t1_ch_ptr", 32'(ia.ch_ptr), 32'd0);
    ia.out_ready = 4'b1011;
    send_a(1'b1, 8'h18); send_a(1'b0, 8'h19); send_a(1'b0, 8'h1A); send_a(1'b0, 8'h1B);
    send_a(1'b1, 8'h20); send_a(1'b0, 8'h21);
    fork
      send_a(1'b0, 8'h22);
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("t2_in_ready_stall", 32'(ia.in_ready), 32'd0);
        chk("t2_ch_ptr", 32'(ia.ch_ptr), 32'd2);
        chk("t2_lane2_old", 32'(ia.out_data[23:16]), 32'h1A);
        ia.out_ready = 4'hF;
      end
    join
    chk("t2_lane2_new", 32'(ia.out_data[23:16]), 32'h22);
    chk("t2_valid2", 32'(ia.out_valid[2]), 32'd1);
    send_a(1'b0, 8'h23);
    ia.out_ready = 4'b1101;
    send_a(1'b1, 8'hA0); send_a(1'b0, 8'hA1); send_a(1'b1, 8'hB0);
    chk("t3_frame_err", 32'(ia.frame_err), 32'd1);
    chk("t3_lane0", 32'(ia.out_data[7:0]), 32'hB0);
    chk("t3_ch_ptr", 32'(ia.ch_ptr), 32'd1);
    chk("t3_lane1", 32'(ia.out_data[15:8]), 32'hA1);
    chk("t3_valid1", 32'(ia.out_valid[1]), 32'd1);
    ia.out_ready = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    c0 = done_b;
    for (int k = 0; k < 7; k++) send_b(k == 0, 16'h1000 + 16'(k));
    chk("t4_lane0", 32'(ib.out_data[15:0]), 32'h1006);
    chk("t4_valid", 32'(ib.out_valid), 32'b001);
    repeat (2) @(posedge clk);
    #1;
    chk("t4_done_count", 32'(done_b - c0), 32'd2);
    chk("t4_ch_ptr", 32'(ib.ch_ptr), 32'd1);
    chk("t4_ptr_range", 32'(bad_ptr_b), 32'd0);
    ia.out_ready = 4'h0;
    send_a(1'b1, 8'hC0); send_a(1'b0, 8'hC1); send_a(1'b0, 8'hC2);
    chk("t5_pre_ptr", 32'(ia.ch_ptr), 32'd3);
    chk("t5_pre_valid", 32'(ia.out_valid), 32'b0111);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_out_valid", 32'(ia.out_valid), 32'd0);
    chk("t5_out_data", ia.out_data, 32'd0);
    chk("t5_ch_ptr", 32'(ia.ch_ptr), 32'd0);
    chk("t5_pulses", {30'd0, ia.frame_done, ia.frame_err}, 32'd0);
    chk("t5_in_ready", 32'(ia.in_ready), 32'd1);
    rst = 1'b0;
    fork
      begin
        for (int k = 0; k < 10000; k++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send_a($urandom_range(0, 7) == 0, 8'($urandom));
        end
        rdone = 1'b1;
      end
      while (!rdone) begin
        @(posedge clk);
        #1;
        ia.out_ready = 4'($urandom) | 4'($urandom);
      end
    join
    ia.out_ready = 4'hF;
    repeat (10) @(posedge clk);
    #1;
    chk("a_queue_empty", 32'(qa.size()), 32'd0);
    chk("b_queue_empty", 32'(qb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
